// File: rtl/test_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_clk_pkg
// Description : Shared constants and sizing helpers for the board bring-up
//               block (oscillator heartbeat + debounced push-button toggle).
// Revision    : 1.0 - initial release
// ============================================================================
package test_clk_pkg;

    localparam int DEFAULT_OSC_F        = 24000000;
    localparam int DEFAULT_DEBOUNCE_DIV = 100;
    localparam int MIN_DB_LEN           = 2;

    // Bit positions within the LED vector
    localparam int LED_HEART = 0;
    localparam int LED_HALF  = 1;
    localparam int LED_BTN   = 2;

    typedef logic [2:0] led_t;

    // Lower-bound a derived constant (guards tiny simulation frequencies)
    function automatic int clamp_min(input int value, input int lo);
        return (value < lo) ? lo : value;
    endfunction

    // Bits needed for a counter that runs 0..n-1; never less than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : test_clk_pkg
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Two-flop synchroniser followed by a debounce counter. The
//               debounced level follows the synchronised button only after
//               it has disagreed for DB_LEN consecutive cycles.
// Ports       : clk      - clock
//               rst      - synchronous active-high reset
//               i_button - raw button level, asynchronous to clk
//               o_level  - registered debounced level
//               o_rise   - one-cycle pulse, high in the cycle whose closing
//                          edge moves o_level from 0 to 1
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
    import test_clk_pkg::*;
#(
    parameter int DB_LEN = MIN_DB_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic i_button,
    output logic o_level,
    output logic o_rise
);

    localparam int             C_CW   = cnt_width(DB_LEN);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(DB_LEN - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            level_q, level_d;
    logic [C_CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = i_button;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == C_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level = level_q;
    // Decoded from the next-state so the consumer can act on the same edge
    // that commits the new level; driven only by flops, never by i_button.
    assign o_rise  = level_d & ~level_q;

endmodule : button_debouncer
`default_nettype wire

// File: rtl/test_24mhz_clock.sv
`default_nettype none
// ============================================================================
// Module      : test_24mhz_clock
// Description : Board bring-up block. led[0] is a heartbeat toggling every
//               OSC_F/2 cycles (1 Hz when OSC_F is correct), led[1] toggles
//               at half that rate, led[2] toggles on each debounced press.
// Ports       : clk    - board oscillator clock
//               rst    - synchronous active-high reset
//               button - raw push-button, active-high, asynchronous
//               led    - [0] heartbeat, [1] half-rate heartbeat,
//                        [2] button toggle (all registered)
// Config      : TEST_24MHZ_LED_ACTIVE_LOW_EN - when defined, led pins are
//               driven inverted for active-low LEDs (3'b111 in reset).
// Revision    : 1.0 - initial release
// ============================================================================
module test_24mhz_clock
    import test_clk_pkg::*;
#(
    parameter int OSC_F        = DEFAULT_OSC_F,
    parameter int DEBOUNCE_DIV = DEFAULT_DEBOUNCE_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    output logic [2:0] led
);

    localparam int              C_HALF   = clamp_min(OSC_F / 2, 1);
    localparam int              C_DB_LEN = clamp_min(OSC_F / DEBOUNCE_DIV, MIN_DB_LEN);
    localparam int              C_PW     = cnt_width(C_HALF);
    localparam logic [C_PW-1:0] C_TERM   = C_PW'(C_HALF - 1);

    logic [C_PW-1:0] cnt_q,   cnt_d;
    logic            phase_q, phase_d;
    led_t            led_q,   led_d;
    logic            w_tick;
    logic            w_btn_level;
    logic            w_btn_rise;

    button_debouncer #(
        .DB_LEN   (C_DB_LEN)
    ) u_button_debouncer (
        .clk      (clk),
        .rst      (rst),
        .i_button (button),
        .o_level  (w_btn_level),
        .o_rise   (w_btn_rise)
    );

    always_comb begin
        w_tick  = (cnt_q == C_TERM);
        cnt_d   = w_tick ? '0 : cnt_q + 1'b1;
        // Phase marks every second tick, which is when the half-rate LED flips
        phase_d = phase_q ^ w_tick;
        led_d   = led_q;
        if (w_tick) begin
            led_d[LED_HEART] = ~led_q[LED_HEART];
            if (phase_q) begin
                led_d[LED_HALF] = ~led_q[LED_HALF];
            end
        end
        // A rise is only ever reported while the held level is still low
        if (w_btn_rise && !w_btn_level) begin
            led_d[LED_BTN] = ~led_q[LED_BTN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            led_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

`ifdef TEST_24MHZ_LED_ACTIVE_LOW_EN
    assign led = ~led_q;
`else
    assign led = led_q;
`endif

endmodule : test_24mhz_clock
`default_nettype wire

// File: tb/tb_test_24mhz_clock.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_24mhz_clock
// Description : Self-checking bench for test_24mhz_clock with OSC_F=5
//               (half period 2 cycles, debounce window 2 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_24mhz_clock;

    localparam int OSC_F  = 5;
    localparam int DIV    = 100;
    localparam int HALF   = (OSC_F / 2 < 1) ? 1 : OSC_F / 2;
    localparam int DB_LEN = (OSC_F / DIV < 2) ? 2 : OSC_F / DIV;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       button = 1'b0;
    logic [2:0] led;

    test_24mhz_clock #(
        .OSC_F        (OSC_F),
        .DEBOUNCE_DIV (DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .led    (led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: edges since reset, history of sampled button levels,
    // debounced level and button-toggle LED.
    int k = 0;
    int hist[$];
    bit mdb   = 1'b0;
    bit mled2 = 1'b0;

    typedef struct {
        bit         rst;
        bit         button;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [2:0] phys(input logic [2:0] v);
`ifdef TEST_24MHZ_LED_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    function automatic logic [2:0] model_led();
        logic b0, b1;
        b0 = ((k / HALF) % 2) != 0;
        b1 = ((k / (2 * HALF)) % 2) != 0;
        return {mled2, b1, b0};
    endfunction

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: led=%b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Debounced level flips when the DB_LEN samples that have reached the
    // synchroniser output (taken 2+ edges ago) all disagree with it.
    task automatic model_update(input bit r, input bit b);
        int n;
        int s;
        bit flip;
        if (r) begin
            k = 0;
            hist.delete();
            hist.push_back(0);
            mdb   = 1'b0;
            mled2 = 1'b0;
        end else begin
            k++;
            hist.push_back(int'(b));
            n = hist.size() - 1;
            flip = 1'b1;
            for (int j = n - DB_LEN - 1; j <= n - 2; j++) begin
                s = (j >= 0) ? hist[j] : 0;
                if (s == int'(mdb)) flip = 1'b0;
            end
            if (flip) begin
                mdb = ~mdb;
                if (mdb) mled2 = ~mled2;
            end
        end
    endtask

    task automatic step(input bit r, input bit b);
        rst    = r;
        button = b;
        @(posedge clk);
        model_update(r, b);
        #1;
        check3("model", led, phys(model_led()));
    endtask

    // Hold the button for len cycles, report edges until led[2] changes
    task automatic press(input string name, input int len, input int exp_lat);
        logic [2:0] v;
        logic       prev;
        int         lat;
        v    = phys(led);
        prev = v[2];
        lat  = -1;
        for (int i = 1; i <= len; i++) begin
            step(1'b0, 1'b1);
            v = phys(led);
            if (lat < 0 && v[2] != prev) lat = i;
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0);
            v = phys(led);
            if (lat < 0 && v[2] != prev) lat = len + 1 + i;
        end
        check_int(name, lat, exp_lat);
    endtask

    initial begin
        logic [2:0] v;
        bit         r;
        bit         b;

        // Reset three cycles, then release with the button low
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 1'b0, 3'b000};
        tbl[3]  = '{1'b0, 1'b0, 3'b000};
        tbl[4]  = '{1'b0, 1'b0, 3'b001};
        tbl[5]  = '{1'b0, 1'b0, 3'b001};
        tbl[6]  = '{1'b0, 1'b0, 3'b010};
        tbl[7]  = '{1'b0, 1'b0, 3'b010};
        tbl[8]  = '{1'b0, 1'b0, 3'b011};
        tbl[9]  = '{1'b0, 1'b0, 3'b011};
        tbl[10] = '{1'b0, 1'b0, 3'b000};

        for (int i = 0; i < 11; i++) begin
            rst    = tbl[i].rst;
            button = tbl[i].button;
            @(posedge clk);
            model_update(tbl[i].rst, tbl[i].button);
            #1;
            check3("vector", led, phys(tbl[i].exp));
            check3("vector_model", led, phys(model_led()));
        end

        // First press sets led[2] after 2+DB_LEN edges, second clears it
        press("press1_latency", 10, 2 + DB_LEN);
        v = phys(led);
        check_int("press1_led2", int'(v[2]), 1);
        press("press2_latency", 10, 2 + DB_LEN);
        v = phys(led);
        check_int("press2_led2", int'(v[2]), 0);

        // Single-cycle glitch is filtered out
        press("glitch", 1, -1);

        // Reset mid-count and mid-debounce
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check3("mid_reset", led, phys(3'b000));
        step(1'b0, 1'b0);
        v = phys(led);
        check_int("restart_edge1_led0", int'(v[0]), 0);
        step(1'b0, 1'b0);
        v = phys(led);
        check_int("restart_edge2_led0", int'(v[0]), 1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);

        // Randomised runs of button levels with occasional resets
        b = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) b = ~b;
            step(r, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_test_24mhz_clock
`default_nettype wire
